// File: rtl/key_event_decoder_pkg.sv
// Shared definitions for the key event decoder: FSM state encoding, default
// thresholds and the electrical polarity of a pressed key.
package key_event_decoder_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESSED = 2'd1,
    S_LONG    = 2'd2
  } key_state_t;

  localparam int          DEF_CNT_W      = 26;
  localparam int unsigned DEF_LONG_MAX   = 50_000_000;  // 1 s at 50 MHz
  localparam int unsigned DEF_REPEAT_MAX = 10_000_000;  // 200 ms at 50 MHz

  localparam logic KEY_PRESSED = 1'b0;
  localparam logic KEY_IDLE    = ~KEY_PRESSED;

endpackage

// File: rtl/key_event_decoder_edge_detect.sv
// Registers the debounced key level and flags press (fall) and release (rise)
// edges combinationally against the registered copy.
module key_edge_detect
  import key_event_decoder_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic key_filtered,
  output logic fall,
  output logic rise
);

  logic key_prev_reg;
  logic prev_valid_reg;

  // prev_valid_reg masks the first cycle after reset, so a key already held
  // down while reset was asserted is never mistaken for a fresh press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_prev_reg   <= KEY_IDLE;
      prev_valid_reg <= 1'b0;
    end else begin
      key_prev_reg   <= key_filtered;
      prev_valid_reg <= 1'b1;
    end
  end

  assign fall = prev_valid_reg && (key_prev_reg == KEY_IDLE) && (key_filtered == KEY_PRESSED);
  assign rise = prev_valid_reg && (key_prev_reg == KEY_PRESSED) && (key_filtered == KEY_IDLE);

endmodule

// File: rtl/key_event_decoder.sv
// Turns one debounced active-low key into single-cycle press / short / long /
// repeat / release pulses plus a key_held level, all registered.
module key_event_decoder
  import key_event_decoder_pkg::*;
#(
  parameter int          CNT_W      = DEF_CNT_W,
  parameter int unsigned LONG_MAX   = DEF_LONG_MAX,
  parameter int unsigned REPEAT_MAX = DEF_REPEAT_MAX
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_filtered,
  output logic press_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic release_pulse,
  output logic key_held
);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_MAX - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic fall;
  logic rise;

  key_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic press_reg, press_next;
  logic short_reg, short_next;
  logic long_reg, long_next;
  logic repeat_reg, repeat_next;
  logic release_reg, release_next;
  logic held_reg, held_next;

  key_edge_detect u_edge (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_filtered (key_filtered),
    .fall         (fall),
    .rise         (rise)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      press_reg   <= 1'b0;
      short_reg   <= 1'b0;
      long_reg    <= 1'b0;
      repeat_reg  <= 1'b0;
      release_reg <= 1'b0;
      held_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      press_reg   <= press_next;
      short_reg   <= short_next;
      long_reg    <= long_next;
      repeat_reg  <= repeat_next;
      release_reg <= release_next;
      held_reg    <= held_next;
    end
  end

  // A release always beats a threshold hit on the same cycle, so a key let go
  // exactly at the long boundary still counts as a short press.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    press_next   = 1'b0;
    short_next   = 1'b0;
    long_next    = 1'b0;
    repeat_next  = 1'b0;
    release_next = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (fall) begin
          press_next = 1'b1;
          cnt_next   = '0;
          state_next = S_PRESSED;
        end
      end
      S_PRESSED: begin
        if (rise) begin
          short_next   = 1'b1;
          release_next = 1'b1;
          cnt_next     = '0;
          state_next   = S_IDLE;
        end else if (cnt_reg == LONG_LAST) begin
          long_next  = 1'b1;
          cnt_next   = '0;
          state_next = S_LONG;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      S_LONG: begin
        if (rise) begin
          release_next = 1'b1;
          cnt_next     = '0;
          state_next   = S_IDLE;
        end else if (cnt_reg == REPEAT_LAST) begin
          repeat_next = 1'b1;
          cnt_next    = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = S_IDLE;
      end
    endcase

    held_next = (state_next == S_PRESSED) || (state_next == S_LONG);
  end

  assign press_pulse   = press_reg;
  assign short_pulse   = short_reg;
  assign long_pulse    = long_reg;
  assign repeat_pulse  = repeat_reg;
  assign release_pulse = release_reg;
  assign key_held      = held_reg;

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder with LONG_MAX=10, REPEAT_MAX=4.
module tb_key_event_decoder;

  logic clk = 1'b0;
  logic rst_n;
  logic key_filtered;
  logic press_pulse, short_pulse, long_pulse, repeat_pulse, release_pulse, key_held;

  int errors = 0;
  int checks = 0;

  localparam int WIN = 40;

  key_event_decoder #(
    .CNT_W      (26),
    .LONG_MAX   (10),
    .REPEAT_MAX (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_filtered  (key_filtered),
    .press_pulse   (press_pulse),
    .short_pulse   (short_pulse),
    .long_pulse    (long_pulse),
    .repeat_pulse  (repeat_pulse),
    .release_pulse (release_pulse),
    .key_held      (key_held)
  );

  always #5 clk = ~clk;

  // Output vector order: {press, short, long, repeat, release, held}
  task automatic check(input string name, input int cyc, input logic [5:0] exp);
    logic [5:0] got;
    got = {press_pulse, short_pulse, long_pulse, repeat_pulse, release_pulse, key_held};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d: got %b required %b (press,short,long,repeat,release,held)",
               name, cyc, got, exp);
    end
  endtask

  // Key goes low before cycle 1's edge and stays low for `low` edges; cycle
  // numbers below are the edge index after which the output is seen.
  typedef struct {
    string name;
    int    low;
    int    short_at;
    int    long_at;
    int    rep_first;
    int    rep_n;
    int    rel_at;
  } case_t;

  case_t cases[7];

  task automatic run_case(input case_t tc);
    logic [5:0] exp;
    bit is_rep;
    int err0;
    err0 = errors;
    @(negedge clk);
    key_filtered = 1'b0;
    for (int c = 1; c <= WIN; c++) begin
      @(posedge clk);
      #1;
      is_rep = (tc.rep_n > 0) && (c >= tc.rep_first) && ((c - tc.rep_first) % 4 == 0)
               && ((c - tc.rep_first) / 4 < tc.rep_n);
      exp = {c == 1, c == tc.short_at, c == tc.long_at, is_rep, c == tc.rel_at,
             (c >= 1) && (c < tc.rel_at)};
      check(tc.name, c, exp);
      @(negedge clk);
      if (c == tc.low) key_filtered = 1'b1;
    end
    $display("case %-16s low=%0d cycles: %0d new errors", tc.name, tc.low, errors - err0);
  endtask

  logic [5:0] b2b_exp [1:10];
  logic       b2b_key [1:10];

  initial begin
    cases[0] = '{"short5",          5,  6,  0,  0, 0,  6};
    cases[1] = '{"short9",          9, 10,  0,  0, 0, 10};
    cases[2] = '{"rel_at_long_thr", 10, 11, 0,  0, 0, 11};
    cases[3] = '{"long11",          11, 0, 11,  0, 0, 12};
    cases[4] = '{"rel_at_rep_thr",  14, 0, 11,  0, 0, 15};
    cases[5] = '{"rep15",           15, 0, 11, 15, 1, 16};
    cases[6] = '{"hold25",          25, 0, 11, 15, 3, 26};

    b2b_exp[1] = 6'b100001; b2b_key[1] = 1'b0;
    b2b_exp[2] = 6'b000001; b2b_key[2] = 1'b0;
    b2b_exp[3] = 6'b000001; b2b_key[3] = 1'b1;
    b2b_exp[4] = 6'b010010; b2b_key[4] = 1'b0;
    b2b_exp[5] = 6'b100001; b2b_key[5] = 1'b0;
    b2b_exp[6] = 6'b000001; b2b_key[6] = 1'b0;
    b2b_exp[7] = 6'b000001; b2b_key[7] = 1'b1;
    b2b_exp[8] = 6'b010010; b2b_key[8] = 1'b1;
    b2b_exp[9] = 6'b000000; b2b_key[9] = 1'b1;
    b2b_exp[10] = 6'b000000; b2b_key[10] = 1'b1;

    // Key held low through reset and beyond: nothing may happen.
    rst_n = 1'b0;
    key_filtered = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 0, 6'b000000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      @(posedge clk);
      #1;
      check("held_thru_reset", c, 6'b000000);
    end
    @(negedge clk);
    key_filtered = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      #1;
      check("rise_in_idle", c, 6'b000000);
    end
    $display("case held_thru_reset done: errors so far %0d", errors);

    for (int i = 0; i < 7; i++) run_case(cases[i]);

    // Back-to-back presses: 3 low, 1 high, 3 low.
    @(negedge clk);
    key_filtered = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      check("back_to_back", c, b2b_exp[c]);
      @(negedge clk);
      key_filtered = b2b_key[c];
    end
    $display("case back_to_back done: errors so far %0d", errors);

    // Reset while in LONG: outputs clear at once, no events until a new press.
    @(negedge clk);
    key_filtered = 1'b0;
    for (int c = 1; c <= 14; c++) @(posedge clk);
    #1;
    check("in_long_before_rst", 14, 6'b000001);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst_now", 0, 6'b000000);
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk);
      #1;
      check("in_reset", c, 6'b000000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      check("low_after_rst", c, 6'b000000);
    end
    @(negedge clk);
    key_filtered = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      #1;
      check("release_after_rst", c, 6'b000000);
    end
    $display("case rst_in_long done: errors so far %0d", errors);
    run_case(cases[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
